// File: rtl/axil_crossbar_pkg.sv
// Shared definitions for the AXI-Lite priority interconnect arbiters.
// Used by both the write-side and the read-side arbiter.
package axil_crossbar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT  = 2'b01,
    ERR_AW = 2'b10,
    ERR_B  = 2'b11
  } wr_arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Index width for a slave count; never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/axil_crossbar_addr_dec.sv
// Combinational address-window decoder.
// Compares an address against every slave window and reports:
//   - a one-hot-or-more match vector,
//   - a hit flag,
//   - the lowest matching index.
// Shared by the read and write arbiters.
module axil_crossbar_addr_dec
  import axil_crossbar_pkg::*;
#(
  parameter int NUMBER_SLAVE   = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int IDX_W          = idx_width(NUMBER_SLAVE),
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_BASE_ADDR = '0,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_ADDR_MASK = '0
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic [NUMBER_SLAVE-1:0]   match,
  output logic                      hit,
  output logic [IDX_W-1:0]          idx
);

  // Masked window compare for every slave.
  always_comb begin
    match = {NUMBER_SLAVE{1'b0}};
    for (int j = 0; j < NUMBER_SLAVE; j++) begin
      match[j] = ((addr & SLAVE_ADDR_MASK[j]) == (SLAVE_BASE_ADDR[j] & SLAVE_ADDR_MASK[j]));
    end
  end

  assign hit = |match;

  // Priority encode.
  // The scan walks downward so that the lowest matching index is written last and wins.
  always_comb begin
    idx = {IDX_W{1'b0}};
    for (int j = NUMBER_SLAVE - 1; j >= 0; j--) begin
      idx = match[j] ? IDX_W'(j) : idx;
    end
  end

endmodule

// File: rtl/axil_crossbar_arb_wr.sv
// Write-transaction arbiter for one master port of the AXI-Lite interconnect.
// Decodes AWADDR and holds a one-hot slave grant from AW acceptance through the B handshake.
// Optional feature macro: AXIL_DECERR_EN.
//   When defined, an internal responder answers unmapped writes with DECERR.
//   When undefined, unmapped writes are steered to slave 0.
module axil_crossbar_arb_wr
  import axil_crossbar_pkg::*;
#(
  parameter int NUMBER_SLAVE   = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_BASE_ADDR = '0,
  parameter logic [NUMBER_SLAVE-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_ADDR_MASK = '0
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_ADDR_WIDTH-1:0] m_axil_awaddr,
  input  logic                      m_axil_awvalid,
  input  logic                      m_axil_wvalid,
  input  logic                      m_axil_bready,
  input  logic                      m_axil_awready,
  input  logic                      m_axil_bvalid,
  output logic [NUMBER_SLAVE-1:0]   grant_wr_trans,
  output logic                      dec_awready,
  output logic                      dec_wready,
  output logic                      dec_bvalid,
  output logic [1:0]                dec_bresp
);

  localparam int IDX_W = idx_width(NUMBER_SLAVE);
  localparam logic [NUMBER_SLAVE-1:0] DEFAULT_GRANT = NUMBER_SLAVE'(1'b1);

  logic [NUMBER_SLAVE-1:0] match_s;
  logic                    hit_s;
  logic [IDX_W-1:0]        idx_s;
  logic [NUMBER_SLAVE-1:0] grant_next_s;
  logic [NUMBER_SLAVE-1:0] grant_r;
  wr_arb_state_t           state_r;
  logic                    unused_s;

  axil_crossbar_addr_dec #(
    .NUMBER_SLAVE    (NUMBER_SLAVE),
    .AXI_ADDR_WIDTH  (AXI_ADDR_WIDTH),
    .IDX_W           (IDX_W),
    .SLAVE_BASE_ADDR (SLAVE_BASE_ADDR),
    .SLAVE_ADDR_MASK (SLAVE_ADDR_MASK)
  ) u_addr_dec (
    .addr  (m_axil_awaddr),
    .match (match_s),
    .hit   (hit_s),
    .idx   (idx_s)
  );

  // Grant for the decoded slave; slave 0 is the fallback when nothing matches.
  always_comb begin
    if (hit_s) begin
      grant_next_s = DEFAULT_GRANT << idx_s;
    end else begin
      grant_next_s = DEFAULT_GRANT;
    end
  end

`ifdef AXIL_DECERR_EN
  logic       dec_awready_r;
  logic       dec_wready_r;
  logic       dec_bvalid_r;
  logic [1:0] dec_bresp_r;
  logic       aw_done_r;
  logic       w_done_r;
  logic       aw_hs_s;
  logic       w_hs_s;

  assign aw_hs_s = dec_awready_r && m_axil_awvalid;
  assign w_hs_s  = dec_wready_r && m_axil_wvalid;

  // Transaction FSM.
  // Holds the slave grant, or runs the DECERR responder for unmapped writes.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r       <= IDLE;
      grant_r       <= {NUMBER_SLAVE{1'b0}};
      dec_awready_r <= 1'b0;
      dec_wready_r  <= 1'b0;
      dec_bvalid_r  <= 1'b0;
      dec_bresp_r   <= RESP_OKAY;
      aw_done_r     <= 1'b0;
      w_done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (m_axil_awvalid) begin
            if (hit_s) begin
              grant_r <= grant_next_s;
              state_r <= GRANT;
            end else begin
              dec_awready_r <= 1'b1;
              dec_wready_r  <= 1'b1;
              aw_done_r     <= 1'b0;
              w_done_r      <= 1'b0;
              state_r       <= ERR_AW;
            end
          end
        end
        GRANT: begin
          if (m_axil_bvalid && m_axil_bready) begin
            grant_r <= {NUMBER_SLAVE{1'b0}};
            state_r <= IDLE;
          end
        end
        ERR_AW: begin
          if (aw_hs_s) begin
            dec_awready_r <= 1'b0;
            aw_done_r     <= 1'b1;
          end
          if (w_hs_s) begin
            dec_wready_r <= 1'b0;
            w_done_r     <= 1'b1;
          end
          // AW and W may finish in either order or together.
          if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
            dec_bvalid_r <= 1'b1;
            dec_bresp_r  <= RESP_DECERR;
            state_r      <= ERR_B;
          end
        end
        ERR_B: begin
          if (m_axil_bready) begin
            dec_bvalid_r <= 1'b0;
            dec_bresp_r  <= RESP_OKAY;
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= {NUMBER_SLAVE{1'b0}};
        end
      endcase
    end
  end

  assign dec_awready = dec_awready_r;
  assign dec_wready  = dec_wready_r;
  assign dec_bvalid  = dec_bvalid_r;
  assign dec_bresp   = dec_bresp_r;
  assign unused_s    = ^{match_s, m_axil_awready};
`else
  // Transaction FSM.
  // Holds the slave grant; unmapped writes go to the default slave.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r <= IDLE;
      grant_r <= {NUMBER_SLAVE{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (m_axil_awvalid) begin
            grant_r <= grant_next_s;
            state_r <= GRANT;
          end
        end
        GRANT: begin
          if (m_axil_bvalid && m_axil_bready) begin
            grant_r <= {NUMBER_SLAVE{1'b0}};
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= {NUMBER_SLAVE{1'b0}};
        end
      endcase
    end
  end

  assign dec_awready = 1'b0;
  assign dec_wready  = 1'b0;
  assign dec_bvalid  = 1'b0;
  assign dec_bresp   = RESP_OKAY;
  assign unused_s    = ^{match_s, hit_s, m_axil_awready, m_axil_wvalid};
`endif

  assign grant_wr_trans = grant_r;

endmodule

// File: tb/tb_axil_crossbar_arb_wr.sv
// Self-checking bench for axil_crossbar_arb_wr.
// Expected values come from a window-decode reference model and transaction-level timing rules.
// Adapts to AXIL_DECERR_EN.
module tb_axil_crossbar_arb_wr;

  localparam int NS = 4;
  localparam logic [NS-1:0][31:0] BASES     = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS-1:0][31:0] MASKS     = {4{32'hF000_0000}};
  localparam logic [NS-1:0][31:0] MASKS_OVL = {32'hF000_0000, 32'hF000_0000, 32'h0000_0000, 32'hF000_0000};

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          areset_ovl = 1'b1;
  logic [31:0]   awaddr = 32'h0;
  logic          awvalid = 1'b0;
  logic          wvalid = 1'b0;
  logic          bready = 1'b0;
  logic          awready = 1'b0;
  logic          bvalid = 1'b0;
  logic [NS-1:0] grant, grant_ovl;
  logic          dec_awready, dec_wready, dec_bvalid;
  logic [1:0]    dec_bresp;
  logic          ovl_awready, ovl_wready, ovl_bvalid;
  logic [1:0]    ovl_bresp;

  int n_vec = 0;
  int n_err = 0;
  bit ovl_on = 1'b0;

  always #5 clk = ~clk;

  axil_crossbar_arb_wr #(
    .NUMBER_SLAVE(NS), .AXI_ADDR_WIDTH(32),
    .SLAVE_BASE_ADDR(BASES), .SLAVE_ADDR_MASK(MASKS)
  ) dut (
    .aclk(clk), .areset(areset), .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid),
    .m_axil_wvalid(wvalid), .m_axil_bready(bready), .m_axil_awready(awready),
    .m_axil_bvalid(bvalid), .grant_wr_trans(grant), .dec_awready(dec_awready),
    .dec_wready(dec_wready), .dec_bvalid(dec_bvalid), .dec_bresp(dec_bresp)
  );

  axil_crossbar_arb_wr #(
    .NUMBER_SLAVE(NS), .AXI_ADDR_WIDTH(32),
    .SLAVE_BASE_ADDR(BASES), .SLAVE_ADDR_MASK(MASKS_OVL)
  ) dut_ovl (
    .aclk(clk), .areset(areset_ovl), .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid),
    .m_axil_wvalid(wvalid), .m_axil_bready(bready), .m_axil_awready(awready),
    .m_axil_bvalid(bvalid), .grant_wr_trans(grant_ovl), .dec_awready(ovl_awready),
    .dec_wready(ovl_wready), .dec_bvalid(ovl_bvalid), .dec_bresp(ovl_bresp)
  );

  // Reference decode: lowest matching window wins.
  function automatic bit ref_hit(input logic [31:0] a, input bit ovl);
    logic [31:0] m;
    logic [31:0] b;
    for (int j = 0; j < NS; j++) begin
      m = (ovl && j == 1) ? 32'h0 : 32'hF000_0000;
      b = j * 32'h1000_0000;
      if ((a & m) == (b & m)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [NS-1:0] ref_grant(input logic [31:0] a, input bit ovl);
    logic [31:0] m;
    logic [31:0] b;
    for (int j = 0; j < NS; j++) begin
      m = (ovl && j == 1) ? 32'h0 : 32'hF000_0000;
      b = j * 32'h1000_0000;
      if ((a & m) == (b & m)) return NS'(1 << j);
    end
`ifdef AXIL_DECERR_EN
    return 4'b0000;
`else
    return 4'b0001;
`endif
  endfunction

  function automatic bit ref_err(input logic [31:0] a);
`ifdef AXIL_DECERR_EN
    return !ref_hit(a, 1'b0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk_eq(tag, {grant, dec_awready, dec_wready, dec_bvalid, dec_bresp}, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mapped (or default-slave) write: grant from AW edge until the cycle after B handshake.
  task automatic wr_grant(input logic [31:0] addr, input int hold, input int bwait,
                          input bit chain, input logic [31:0] next_addr);
    logic [NS-1:0] eg;
    eg = ref_grant(addr, 1'b0);
    awaddr = addr; awvalid = 1'b1; wvalid = 1'($urandom_range(1, 0));
    bvalid = 1'b0; bready = 1'b0;
    tick();
    chk_eq("grant_on", grant, eg);
    chk_eq("grant_dec", {dec_awready, dec_wready, dec_bvalid}, 32'h0);
    if (ovl_on) chk_eq("ovl_grant", grant_ovl, ref_grant(addr, 1'b1));
    awready = 1'b1;
    tick();
    awvalid = 1'b0; awready = 1'b0; wvalid = 1'b0;
    chk_eq("grant_hold", grant, eg);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk_eq("grant_hold", grant, eg);
    end
    bvalid = 1'b1;
    for (int i = 0; i < bwait; i++) begin
      tick();
      chk_eq("grant_bwait", grant, eg);
    end
    bready = 1'b1;
    if (chain) begin
      awaddr = next_addr;
      awvalid = 1'b1;
    end
    tick();
    bvalid = 1'b0; bready = 1'b0;
    chk_idle("grant_rel");
    if (ovl_on) chk_eq("ovl_rel", grant_ovl, 32'h0);
  endtask

  // Unmapped write answered by the internal responder.
  // pre > 0 presents W that many cycles before AW.
  task automatic wr_err(input logic [31:0] addr, input int pre, input int wlag, input int bdly);
    int t_w;
    int h;
    awaddr = addr; bvalid = 1'b0; bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    if (pre > 0) begin
      wvalid = 1'b1;
      wlag = 0;
      for (int i = 0; i < pre; i++) begin
        tick();
        chk_idle("w_only");
      end
    end
    awvalid = 1'b1;
    tick();
    chk_eq("err_grant0", grant, 32'h0);
    chk_eq("err_start", {dec_awready, dec_wready, dec_bvalid}, 32'h6);
    t_w = 1 + wlag;
    h = t_w + 1 + bdly;
    for (int rel = 1; rel <= h; rel++) begin
      awvalid = (rel == 1);
      wvalid = (pre > 0) ? (rel <= t_w) : (rel == t_w);
      bready = (rel == h);
      tick();
      chk_eq("err_grant", grant, 32'h0);
      chk_eq("err_ctl", {dec_awready, dec_wready, dec_bvalid},
             {29'h0, 1'b0, (rel < t_w), (rel >= t_w && rel < h)});
      if (rel >= t_w && rel < h) chk_eq("err_bresp", dec_bresp, 32'h3);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int top;
    int gap;

    repeat (3) tick();
    chk_eq("rst_grant", grant, 32'h0);
    chk_idle("rst_dec");
    areset = 1'b0;
    tick();
    chk_idle("idle");

    // W without AW does nothing.
    wvalid = 1'b1;
    tick();
    chk_idle("w_alone");
    wvalid = 1'b0;

    // Basic decode.
    wr_grant(32'h2000_0040, 2, 0, 1'b0, 32'h0);

    // Back-to-back with the second AW waiting during the first B handshake.
    wr_grant(32'h1000_0000, 1, 1, 1'b1, 32'h3000_0000);
    wr_grant(32'h3000_0000, 1, 0, 1'b0, 32'h0);

    // Overlapping windows on the second instance.
    areset_ovl = 1'b0;
    ovl_on = 1'b1;
    tick();
    wr_grant(32'h3000_0000, 0, 1, 1'b0, 32'h0);
    wr_grant(32'h0000_1234, 1, 0, 1'b0, 32'h0);
    wr_grant(32'h2000_0008, 0, 0, 1'b0, 32'h0);
    ovl_on = 1'b0;
    areset_ovl = 1'b1;

    // Unmapped write.
`ifdef AXIL_DECERR_EN
    wr_err(32'h4000_0000, 3, 0, 2);
`else
    wr_grant(32'h4000_0000, 1, 1, 1'b0, 32'h0);
`endif

    // Reset while granted.
    awaddr = 32'h2000_0000; awvalid = 1'b1;
    tick();
    chk_eq("pre_rst_grant", grant, 32'h4);
    awvalid = 1'b0; areset = 1'b1;
    tick();
    chk_idle("rst_in_grant");
    areset = 1'b0;
    tick();
    chk_idle("after_rst_grant");
    wr_grant(32'h1000_0010, 1, 0, 1'b0, 32'h0);

`ifdef AXIL_DECERR_EN
    // Reset while the error response is pending.
    awaddr = 32'h5000_0000; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk_eq("pre_rst_bvalid", {dec_bvalid, dec_bresp}, 32'h7);
    areset = 1'b1;
    tick();
    chk_idle("rst_in_errb");
    areset = 1'b0;
    tick();
    chk_idle("after_rst_errb");
    wr_grant(32'h3000_0100, 0, 1, 1'b0, 32'h0);
`endif

    // Randomized traffic, mapped and unmapped.
    for (int t = 0; t < 60; t++) begin
      top = $urandom_range(5, 0);
      a = {4'(top), 28'($urandom)};
      if (ref_err(a)) begin
        wr_err(a, $urandom_range(2, 0), $urandom_range(3, 0), $urandom_range(2, 0));
      end else begin
        wr_grant(a, $urandom_range(3, 0), $urandom_range(2, 0), 1'b0, 32'h0);
      end
      gap = $urandom_range(2, 0);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk_idle("gap");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
